// File: rtl/caliptra_sram_req_ctrl.sv
// Single-port SRAM initiator: valid/ready requests to SRAM strobes, read data into an in-order response FIFO.
// Optional power-on zeroize walk enabled by `define CALIPTRA_SRAM_REQ_CTRL_ZEROIZE_EN.
module caliptra_sram_req_ctrl #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_cs_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  init_done_o
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0]   RSP_LIMIT = (CW+1)'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(RSP_DEPTH - 1);
  localparam logic [0:0]    ST_ACTIVE = 1'b1;
`ifdef CALIPTRA_SRAM_REQ_CTRL_ZEROIZE_EN
  localparam logic [0:0]    ST_INIT   = 1'b0;
`endif

  logic [0:0]            state_q;
  logic [CW-1:0]         count_q;
  logic                  rd_inflight_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [CW:0]           occupancy;
  logic                  accept;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Reserve a FIFO slot for every read in flight so ready never depends on rsp_ready_i.
  assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, rd_inflight_q};
  assign req_ready_o = (state_q == ST_ACTIVE) && (occupancy < RSP_LIMIT);
  assign init_done_o = (state_q == ST_ACTIVE);
  assign accept      = req_valid_i & req_ready_o;
  assign push        = rd_inflight_q;
  assign rsp_valid_o = (count_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? fifo_q[rd_ptr_q] : '0;

`ifdef CALIPTRA_SRAM_REQ_CTRL_ZEROIZE_EN
  logic [ADDR_WIDTH-1:0] zero_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      zero_addr_q <= '0;
    end else if (state_q == ST_INIT) begin
      zero_addr_q <= zero_addr_q + ADDR_WIDTH'(1);
      if (zero_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_q <= ST_ACTIVE;
      end
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ACTIVE;
    end
  end
`endif

  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
`ifdef CALIPTRA_SRAM_REQ_CTRL_ZEROIZE_EN
    if (state_q == ST_INIT) begin
      sram_cs_o   = 1'b1;
      sram_we_o   = 1'b1;
      sram_addr_o = zero_addr_q;
    end else
`endif
    if (accept) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = req_we_i;
      sram_addr_o  = req_addr_i;
      sram_wdata_o = req_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_inflight_q <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rd_inflight_q <= accept & ~req_we_i;
      if (push) begin
        fifo_q[wr_ptr_q] <= sram_rdata_i;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

`ifndef SYNTHESIS
  rsp_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (push && !pop) |-> (count_q < CW'(RSP_DEPTH)))
    else $error("response fifo overflow");
`endif

endmodule

// File: tb/tb_caliptra_sram_req_ctrl.sv
// Randomized and directed bench for caliptra_sram_req_ctrl with a queue scoreboard and behavioural SRAM.
module tb_caliptra_sram_req_ctrl;
  localparam int DEPTH = 64;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int RD    = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i, req_ready_o, req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o, rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          sram_cs_o, sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o, sram_rdata_i;
  logic          init_done_o;

  always #5 clk_i = ~clk_i;

  caliptra_sram_req_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i), .init_done_o(init_done_o)
  );

  // Behavioural SRAM macro: read data registered, valid the cycle after the strobe.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk_i) begin
    if (sram_cs_o === 1'b1) begin
      if (sram_we_o) sram_mem[sram_addr_o] <= sram_wdata_o;
      else           sram_rdata_i <= sram_mem[sram_addr_o];
    end
  end

  // Reference model: memory contents as seen by the request stream, and expected responses.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] expq [$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 0;
  bit  chk_ready = 0;
  bit  hold_armed = 0;
  logic [DW-1:0] hold_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (init_done_o === 1'b1) begin
        if (req_valid_i && req_ready_o)
          check("strobe_accept", {sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o},
                {1'b1, req_we_i, req_addr_i, req_wdata_i});
        else
          check("strobe_idle", {sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o}, 64'd0);
      end
      if (!rsp_valid_o) check("rdata_idle", rsp_rdata_o, 0);
      if (hold_armed) check("rsp_hold", {rsp_valid_o, rsp_rdata_o}, {1'b1, hold_data});
      if (chk_ready) begin
        check("req_ready", req_ready_o, expq.size() < RD);
        check("init_done", init_done_o, 1);
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (expq.size() == 0) check("unexpected_rsp", rsp_rdata_o, 64'hx);
        else check("rsp_data", rsp_rdata_o, expq.pop_front());
      end
      hold_armed = !rst_i && rsp_valid_o && !rsp_ready_i;
      hold_data  = rsp_rdata_o;
    end
  end

  // Drive one request cycle (called just after a posedge); reports whether it was accepted.
  task automatic step(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output bit acc);
    req_valid_i = v; req_we_i = we; req_addr_i = a; req_wdata_i = d;
    @(negedge clk_i); #2;
    acc = v && req_ready_o;
    if (acc) begin
      if (we) ref_mem[a] = d;
      else    expq.push_back(ref_mem[a]);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, a);
  endtask

  task automatic zero_walk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check("walk_strobe", {sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, init_done_o, req_ready_o},
            {1'b1, 1'b1, AW'(i), 32'd0, 1'b0, 1'b0});
      @(posedge clk_i); #1;
    end
    if (n == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      @(negedge clk_i);
      check("walk_done", {init_done_o, req_ready_o}, 2'b11);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic do_reset(input int n);
    chk_ready = 0;
    expq.delete();
    rst_i = 1; req_valid_i = 0;
    repeat (n) @(posedge clk_i);
    #1 rst_i = 0;
`ifdef CALIPTRA_SRAM_REQ_CTRL_ZEROIZE_EN
    zero_walk(DEPTH);
`endif
    chk_ready = 1;
  endtask

  initial begin
    bit acc;
    int n_acc;
    logic [DW-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    rst_i = 1; req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", {rsp_valid_o, sram_cs_o, rsp_rdata_o}, 0);
    @(posedge clk_i); #1 rst_i = 0;
`ifdef CALIPTRA_SRAM_REQ_CTRL_ZEROIZE_EN
    zero_walk(20);
    rst_i = 1;
    @(posedge clk_i); #1 rst_i = 0;
    zero_walk(DEPTH);
`else
    @(negedge clk_i);
    check("post_reset", {init_done_o, req_ready_o, rsp_valid_o, sram_cs_o}, 4'b1100);
    @(posedge clk_i); #1;
`endif
    mon_en = 1; chk_ready = 1;

    // Write then read back, with response latency check
    rsp_ready_i = 1;
    step(1, 1, 6'd5, 32'hDEADBEEF, acc); check("wr5_acc", acc, 1);
    step(1, 0, 6'd5, '0, acc);           check("rd5_acc", acc, 1);
    req_valid_i = 0;
    @(negedge clk_i); check("lat_cycle1", rsp_valid_o, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i); check("lat_cycle2", {rsp_valid_o, rsp_rdata_o}, {1'b1, 32'hDEADBEEF});
    @(posedge clk_i); #1;
    idle(2);

    // Back-to-back reads at full throughput
    for (int i = 0; i < 8; i++) step(1, 1, AW'(i), 32'h100 + i, acc);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, AW'(i), '0, acc);
      check("b2b_acc", acc, 1);
    end
    req_valid_i = 0;
    @(negedge clk_i); check("b2b_tail6", rsp_valid_o, 1);
    @(posedge clk_i); #1;
    @(negedge clk_i); check("b2b_tail7", rsp_valid_o, 1);
    @(posedge clk_i); #1;
    @(negedge clk_i); check("b2b_empty", rsp_valid_o, 0);
    @(posedge clk_i); #1;

    // Backpressure: exactly RSP_DEPTH reads accepted, then drain and wrap
    rsp_ready_i = 0; n_acc = 0;
    for (int i = 0; i < 6; i++) begin step(1, 0, AW'($urandom), '0, acc); n_acc += int'(acc); end
    check("bp_accepts", n_acc, RD);
    rsp_ready_i = 1; n_acc = 0;
    for (int i = 0; i < 40 && n_acc < 10; i++) begin step(1, 0, AW'($urandom), '0, acc); n_acc += int'(acc); end
    check("wrap_accepts", n_acc, 10);
    idle(4);

    // Push and pop in the same cycle at the occupancy limit
    rsp_ready_i = 0;
    for (int i = 0; i < 3; i++) step(1, 0, AW'(i + 3), '0, acc);
    rsp_ready_i = 1;
    for (int i = 0; i < 5; i++) step(1, 0, AW'(i + 10), '0, acc);
    idle(4);

    // Reset with two buffered and one inflight response
    rsp_ready_i = 0;
    for (int i = 0; i < 3; i++) step(1, 0, AW'(i), '0, acc);
    do_reset(1);
`ifndef CALIPTRA_SRAM_REQ_CTRL_ZEROIZE_EN
    @(negedge clk_i); check("rst_drop", rsp_valid_o, 0);
    @(posedge clk_i); #1;
`endif
    rsp_ready_i = 1;
    idle(3);
    @(negedge clk_i); check("no_stale", rsp_valid_o, 0);
    @(posedge clk_i); #1;

`ifndef CALIPTRA_SRAM_REQ_CTRL_ZEROIZE_EN
    // A write strobed during the reset cycle still lands in the SRAM
    chk_ready = 0; rst_i = 1;
    step(1, 1, 6'd9, 32'hA5A5_0009, acc);
    check("rst_wr_acc", acc, 1);
    rst_i = 0; req_valid_i = 0; chk_ready = 1;
    step(1, 0, 6'd9, '0, acc);
    idle(3);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, AW'($urandom), $urandom, acc);
    end
    rsp_ready_i = 1;
    for (int i = 0; i < 20 && expq.size() != 0; i++) idle(1);
    idle(2);
    check("drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
